multicycle_ctrl_fsm: RTL

Main control state machine for the multicycle CPU. It sequences instruction fetch, decode, execute, memory access and write-back, and drives every datapath enable. This includes the load enable of the register-file-output / ALU-input register stage. It sits beside the datapath, takes the opcode from the instruction register plus a memory ready handshake, and emits a Moore control word per state, gated by `mem_ready` in memory states.

---
 rtl/cpu_ctrl_pkg.sv | 59 +++++
 rtl/ctrl_word_decode.sv | 76 +++++++
 rtl/multicycle_ctrl_fsm.sv | 108 ++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path:
// states, opcodes, datapath select codes and the control word.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       ab_load;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_word_decode.sv
// Moore control word per state; mem_ready gating is
// applied by the FSM top, not here.
module ctrl_word_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e     state_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    cw_o = '0;
    case (state_i)
      S_FETCH: begin
        cw_o.mem_read  = 1'b1;
        cw_o.ir_write  = 1'b1;
        cw_o.pc_write  = 1'b1;
        cw_o.alu_src_b = SRCB_FOUR;
        cw_o.alu_op    = ALU_ADD;
        cw_o.pc_source = PCS_ALU;
      end
      S_DECODE: begin
        cw_o.ab_load   = 1'b1;
        cw_o.alu_src_b = SRCB_IMM_SH;
        cw_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        cw_o.mem_read = 1'b1;
        cw_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.mem_to_reg = 1'b1;
        cw_o.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        cw_o.mem_write  = 1'b1;
        cw_o.iord       = 1'b1;
        cw_o.instr_done = 1'b1;
      end
      S_EXEC: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_B;
        cw_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.reg_dst    = 1'b1;
        cw_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        cw_o.alu_src_a     = 1'b1;
        cw_o.alu_src_b     = SRCB_B;
        cw_o.alu_op        = ALU_SUB;
        cw_o.pc_write_cond = 1'b1;
        cw_o.pc_source     = PCS_ALUOUT;
        cw_o.instr_done    = 1'b1;
      end
      S_JUMP: begin
        cw_o.pc_write   = 1'b1;
        cw_o.pc_source  = PCS_JUMP;
        cw_o.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.instr_done = 1'b1;
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main multicycle CPU control FSM: state register, next-state
// logic and mem_ready gating around the control word decoder.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic           ab_load,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           illegal_op,
  output logic           instr_done,
  output logic [3:0]     state
);

  state_e     state_q;
  state_e     state_d;
  ctrl_word_t cw;
  logic       illegal_d;
  logic       in_fetch;
  logic       in_mem_wr;
  logic       unused_zero;

  // zero only qualifies the PC write in the datapath
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPW'(OP_LW),
          OPW'(OP_SW):   state_d = S_MEM_ADDR;
          OPW'(OP_R):    state_d = S_EXEC;
          OPW'(OP_BEQ):  state_d = S_BRANCH;
          OPW'(OP_J):    state_d = S_JUMP;
          OPW'(OP_ADDI): state_d = S_ADDI_EX;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OPW'(OP_SW)) state_d = S_MEM_WR;
        else                       state_d = S_MEM_RD;
      end
      S_MEM_RD:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_R_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  ctrl_word_decode u_dec (
    .state_i (state_q),
    .cw_o    (cw)
  );

  assign in_fetch  = (state_q == S_FETCH);
  assign in_mem_wr = (state_q == S_MEM_WR);

  // FETCH latches IR/PC and MEM_WR retires only on the ready cycle
  assign pc_write   = cw.pc_write & (mem_ready | ~in_fetch);
  assign ir_write   = cw.ir_write & mem_ready;
  assign instr_done = cw.instr_done & (mem_ready | ~in_mem_wr);

  assign pc_write_cond = cw.pc_write_cond;
  assign iord          = cw.iord;
  assign mem_read      = cw.mem_read;
  assign mem_write     = cw.mem_write;
  assign mem_to_reg    = cw.mem_to_reg;
  assign reg_dst       = cw.reg_dst;
  assign reg_write     = cw.reg_write;
  assign alu_src_a     = cw.alu_src_a;
  assign ab_load       = cw.ab_load;
  assign alu_src_b     = cw.alu_src_b;
  assign alu_op        = cw.alu_op;
  assign pc_source     = cw.pc_source;
  assign illegal_op    = illegal_d;
  assign state         = state_q;

endmodule
